nes_cpu_sequencer: RTL and testbench
====================================

// Module: nes_cpu_sequencer
// PURPOSE
//  Parametrised successor CPU core for the NES top level. It runs a 6502 subset with a real bus-cycle
//  timebase, reset-vector fetch, a flags register, and signed relative branches over the full 16-bit space.
//  It sits between the board clock and the ROM/RAM/PPU address decode.
// PARAMETERS
//  CLK_DIV       12       board clocks per CPU cycle (>=2); 12 gives 1.79 MHz from 21.477 MHz
//  SAMPLE_PHASE  CLK_DIV-1  clock index within a CPU cycle at which data_in is latched (0..CLK_DIV-1)
//  RESET_VECTOR  16'hFFFC   address of the vector low byte; the high byte is read at RESET_VECTOR+1
//  STATUS_RESET  8'h34      P register value after reset (I=1, B=1, bit5=1)
// PORTS
//  clock        in   1   board clock
//  reset        in   1   synchronous, active-high
//  data_in      in   8   read data from the bus decode
//  address_out  out  16  bus address; held stable for the whole CPU cycle
//  data_out     out  8   write data; valid while rw=0
//  rw           out  1   1=read, 0=write
//  sync         out  1   high for the whole opcode-fetch CPU cycle
//  cpu_ce       out  1   one-clock pulse on the last clock of every CPU cycle
//  illegal_op   out  1   one-clock pulse when an unsupported opcode is decoded
//  pc_dbg       out  16  program counter
//  a_dbg, x_dbg, y_dbg, p_dbg  out 8 each  register taps
// BEHAVIOUR
//  Reset (clock, reset synchronous active-high):
//   - Takes effect on any clock, including mid-cycle or mid-instruction. The phase counter is cleared.
//   - Output values: address_out=RESET_VECTOR, rw=1, data_out=0, sync=0, cpu_ce=0, illegal_op=0.
//   - Register values: A=X=Y=0, P=STATUS_RESET, PC=0. The state machine goes to VEC_LO.
//  Timebase:
//   - phase counts 0..CLK_DIV-1 and wraps; cpu_ce=1 when phase==CLK_DIV-1.
//   - All state, address, and rw changes commit on cpu_ce.
//   - data_in is latched at SAMPLE_PHASE.
//  States (one CPU cycle each):
//   - VEC_LO: read RESET_VECTOR into PC[7:0]. Next: VEC_HI.
//   - VEC_HI: read RESET_VECTOR+1 into PC[15:8]. Next: FETCH.
//   - FETCH: sync=1; read opcode at PC; PC+=1. Next: EXEC.
//   - EXEC: read operand at PC. Immediate ops, STA, and branches do PC+=1; implied ops do not.
//     Next: FETCH, WRITE (STA), or BR_TAKE (branch taken).
//   - WRITE: address_out={8'h00,operand}, rw=0, data_out=A. Next: FETCH.
//   - BR_TAKE: dummy read at PC; PC=PC+sext(operand), 16-bit wrap. Next: FETCH, or BR_FIX (see CONFIGURATION).
//   - BR_FIX: dummy read at {old PC[15:8], new PC[7:0]}. Next: FETCH.
//  Opcodes:
//   - A9 LDA#, A2 LDX#, A0 LDY#, 29 AND#, 09 ORA#, 49 EOR#: result written on the EXEC cpu_ce; N=result[7], Z=(result==0).
//   - E8 INX, C8 INY: 8-bit wrap FF->00; N/Z updated.
//   - 18 CLC, 38 SEC, EA NOP: 2 cycles.
//   - 85 STA zp: 3 cycles; flags unchanged.
//   - 10 BPL, 30 BMI, 90 BCC, B0 BCS, D0 BNE, F0 BEQ: not taken = 2 cycles, taken = 3 cycles.
//   - Any other opcode: 2-cycle, 1-byte NOP; illegal_op pulses on the EXEC cpu_ce.
//  Flags:
//   - The branch condition uses P as it stands at the start of EXEC.
//   - Flags written by the previous instruction are visible to the branch.
//  Boundaries:
//   - PC wraps FFFF->0000 on increment.
//   - A branch offset of 8'h80 is -128; 8'h7F is +127.
//   - rw returns to 1 on the cpu_ce that ends WRITE.
// CONFIGURATION
//  CPU_PAGE_PENALTY_EN
//   - Defined: a taken branch whose target high byte differs from the high byte of the post-operand PC
//     passes through BR_FIX (4 cycles).
//   - Undefined: BR_FIX is never entered; every taken branch is 3 cycles with the same final PC.
// TESTING
//  1. Vector fetch: CLK_DIV=12; mem[FFFC]=00, mem[FFFD]=80.
//     -> first sync=1 cycle has address_out=8000; sync rises 24 clocks after reset drops.
//  2. Immediate ops: A9 F0, 29 0F, 09 80.
//     -> A=F0 (N=1, Z=0), then A=00 (Z=1), then A=80 (N=1).
//     -> sync period is 2 CPU cycles per instruction.
//  3. STA: A9 5A, 85 10.
//     -> one cycle with rw=0, address_out=0010, data_out=5A; rw=1 on the next cycle.
//  4. Taken branch across a page: BEQ at 80FD, offset 7F, Z=1.
//     -> next fetch at 817E. 4 CPU cycles with CPU_PAGE_PENALTY_EN, 3 without.
//     -> BR_FIX dummy read at 807E.
//  5. Backward branch and not-taken branch:
//     -> BNE at 8000, offset FE, Z=0: next fetch 8000.
//     -> same with Z=1: next fetch 8002 after 2 cycles.
//  6. Illegal opcode and reset mid-cycle:
//     -> opcode 02: illegal_op pulses once; PC advances by 1.
//     -> reset asserted at phase 5 of WRITE: next clock rw=1, address_out=FFFC; on release, vector fetch restarts.

Source files
------------

// File: rtl/nes_cpu_sequencer.sv
// nes_cpu_sequencer
//   Bus-cycle-accurate 6502-subset CPU core for the NES top level. One CPU
//   cycle lasts CLK_DIV board clocks; every architectural change (state,
//   registers, address, rw) commits on the last board clock of a CPU cycle.
//   After reset the core fetches the reset vector, then runs FETCH/EXEC
//   instruction cycles, with an extra WRITE cycle for STA and extra branch
//   cycles for taken branches.
//
// Build option:
//   CPU_PAGE_PENALTY_EN  when defined, a taken branch whose target lies in a
//                        different page than the post-operand PC spends one
//                        more cycle in BR_FIX (dummy read at the un-carried
//                        address). When undefined, taken branches always
//                        take 3 cycles.
//
// Parameters:
//   CLK_DIV       board clocks per CPU cycle (>= 2)
//   SAMPLE_PHASE  board clock index inside a CPU cycle at which data_in is latched
//   RESET_VECTOR  address of the reset vector low byte
//   STATUS_RESET  P register value after reset
//
// Ports:
//   clock        in   board clock
//   reset        in   synchronous, active-high reset
//   data_in      in   [7:0]  read data from the bus decode
//   address_out  out  [15:0] bus address, stable for a whole CPU cycle
//   data_out     out  [7:0]  write data, valid while rw=0
//   rw           out  1=read, 0=write
//   sync         out  high during the opcode-fetch CPU cycle
//   cpu_ce       out  one-clock pulse on the last board clock of each CPU cycle
//   illegal_op   out  one-clock pulse when an unsupported opcode executes
//   pc_dbg       out  [15:0] program counter
//   a_dbg, x_dbg, y_dbg, p_dbg  out [7:0] register taps

module nes_cpu_sequencer #(
  parameter int          CLK_DIV      = 12,
  parameter int          SAMPLE_PHASE = CLK_DIV - 1,
  parameter logic [15:0] RESET_VECTOR = 16'hFFFC,
  parameter logic [7:0]  STATUS_RESET = 8'h34
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  data_in,
  output logic [15:0] address_out,
  output logic [7:0]  data_out,
  output logic        rw,
  output logic        sync,
  output logic        cpu_ce,
  output logic        illegal_op,
  output logic [15:0] pc_dbg,
  output logic [7:0]  a_dbg,
  output logic [7:0]  x_dbg,
  output logic [7:0]  y_dbg,
  output logic [7:0]  p_dbg
);

  localparam int            PW         = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] SAMPLE_IDX = PW'(SAMPLE_PHASE);

  typedef enum logic [2:0] {
    VEC_LO  = 3'd0,
    VEC_HI  = 3'd1,
    FETCH   = 3'd2,
    EXEC    = 3'd3,
    WRITE   = 3'd4,
    BR_TAKE = 3'd5,
    BR_FIX  = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [7:0]    lat_q, lat_d;
  logic [7:0]    ir_q, ir_d;
  logic [7:0]    op_q, op_d;
  logic [15:0]   pc_q, pc_d;
  logic [7:0]    a_q, a_d;
  logic [7:0]    x_q, x_d;
  logic [7:0]    y_q, y_d;
  logic [7:0]    p_q, p_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    dout_q, dout_d;
  logic          rw_q, rw_d;
  logic          sync_q, sync_d;
  logic          ce_q, ce_d;
  logic          ill_q, ill_d;

  logic          commit;
  logic [7:0]    bus_data;
  logic [15:0]   pc_inc;
  logic [15:0]   target;
  logic          br_taken;
  logic          consume;
  logic          nz_en;
  logic [7:0]    nz_val;

  // Opcodes this core implements; everything else runs as a 1-byte NOP.
  function automatic logic is_supported(input logic [7:0] opc);
    logic ok;
    case (opc)
      8'hA9, 8'hA2, 8'hA0, 8'h29, 8'h09, 8'h49,
      8'hE8, 8'hC8, 8'h18, 8'h38, 8'hEA, 8'h85,
      8'h10, 8'h30, 8'h90, 8'hB0, 8'hD0, 8'hF0: ok = 1'b1;
      default:                                 ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Next-state logic. The timebase runs every clock; the instruction state
  // machine only advances on the commit clock (last phase of a CPU cycle).
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    ir_d     = ir_q;
    op_d     = op_q;
    pc_d     = pc_q;
    a_d      = a_q;
    x_d      = x_q;
    y_d      = y_q;
    p_d      = p_q;
    addr_d   = addr_q;
    dout_d   = dout_q;
    rw_d     = rw_q;
    sync_d   = sync_q;
    consume  = 1'b0;
    nz_en    = 1'b0;
    nz_val   = 8'h00;

    commit  = (phase_q == LAST_PHASE);
    phase_d = commit ? '0 : phase_q + 1'b1;
    ce_d    = (phase_d == LAST_PHASE);

    // When the sample point is the commit clock itself, the latch has not
    // been written yet, so the live bus value is forwarded.
    if (phase_q == SAMPLE_IDX) begin
      lat_d    = data_in;
      bus_data = data_in;
    end else begin
      bus_data = lat_q;
    end

    pc_inc = pc_q + 16'd1;
    target = pc_q + {{8{op_q[7]}}, op_q};

    // Branch condition uses P as committed by the previous instruction.
    case (ir_q)
      8'h10:   br_taken = ~p_q[7];
      8'h30:   br_taken =  p_q[7];
      8'h90:   br_taken = ~p_q[0];
      8'hB0:   br_taken =  p_q[0];
      8'hD0:   br_taken = ~p_q[1];
      8'hF0:   br_taken =  p_q[1];
      default: br_taken = 1'b0;
    endcase

    // The illegal pulse lines up with the cpu_ce of the EXEC cycle.
    ill_d = ce_d && (state_q == EXEC) && !is_supported(ir_q);

    if (commit) begin
      case (state_q)
        VEC_LO: begin
          pc_d[7:0] = bus_data;
          addr_d    = RESET_VECTOR + 16'd1;
          state_d   = VEC_HI;
        end
        VEC_HI: begin
          pc_d    = {bus_data, pc_q[7:0]};
          addr_d  = {bus_data, pc_q[7:0]};
          sync_d  = 1'b1;
          state_d = FETCH;
        end
        FETCH: begin
          ir_d    = bus_data;
          pc_d    = pc_inc;
          addr_d  = pc_inc;
          sync_d  = 1'b0;
          state_d = EXEC;
        end
        EXEC: begin
          op_d    = bus_data;
          state_d = FETCH;
          sync_d  = 1'b1;
          case (ir_q)
            8'hA9: begin a_d = bus_data;        nz_val = bus_data;        nz_en = 1'b1; consume = 1'b1; end
            8'hA2: begin x_d = bus_data;        nz_val = bus_data;        nz_en = 1'b1; consume = 1'b1; end
            8'hA0: begin y_d = bus_data;        nz_val = bus_data;        nz_en = 1'b1; consume = 1'b1; end
            8'h29: begin a_d = a_q & bus_data;  nz_val = a_q & bus_data;  nz_en = 1'b1; consume = 1'b1; end
            8'h09: begin a_d = a_q | bus_data;  nz_val = a_q | bus_data;  nz_en = 1'b1; consume = 1'b1; end
            8'h49: begin a_d = a_q ^ bus_data;  nz_val = a_q ^ bus_data;  nz_en = 1'b1; consume = 1'b1; end
            8'hE8: begin x_d = x_q + 8'd1;      nz_val = x_q + 8'd1;      nz_en = 1'b1; end
            8'hC8: begin y_d = y_q + 8'd1;      nz_val = y_q + 8'd1;      nz_en = 1'b1; end
            8'h18: p_d[0] = 1'b0;
            8'h38: p_d[0] = 1'b1;
            8'h85: begin
              consume = 1'b1;
              state_d = WRITE;
              sync_d  = 1'b0;
              rw_d    = 1'b0;
              dout_d  = a_q;
            end
            8'h10, 8'h30, 8'h90, 8'hB0, 8'hD0, 8'hF0: begin
              consume = 1'b1;
              if (br_taken) begin
                state_d = BR_TAKE;
                sync_d  = 1'b0;
              end
            end
            default: ;
          endcase
          if (consume) pc_d = pc_inc;
          // STA addresses zero page; everything else reads at the new PC
          // (the taken-branch dummy read happens there too).
          if (state_d == WRITE) addr_d = {8'h00, bus_data};
          else                  addr_d = consume ? pc_inc : pc_q;
          if (nz_en) begin
            p_d[7] = nz_val[7];
            p_d[1] = (nz_val == 8'h00);
          end
        end
        WRITE: begin
          rw_d    = 1'b1;
          dout_d  = 8'h00;
          addr_d  = pc_q;
          sync_d  = 1'b1;
          state_d = FETCH;
        end
        BR_TAKE: begin
          pc_d = target;
`ifdef CPU_PAGE_PENALTY_EN
          // Page crossed: the real part first reads with the un-carried high byte.
          if (target[15:8] != pc_q[15:8]) begin
            addr_d  = {pc_q[15:8], target[7:0]};
            state_d = BR_FIX;
          end else begin
            addr_d  = target;
            sync_d  = 1'b1;
            state_d = FETCH;
          end
`else
          addr_d  = target;
          sync_d  = 1'b1;
          state_d = FETCH;
`endif
        end
        BR_FIX: begin
          addr_d  = pc_q;
          sync_d  = 1'b1;
          state_d = FETCH;
        end
        default: begin
          addr_d  = RESET_VECTOR;
          rw_d    = 1'b1;
          sync_d  = 1'b0;
          state_d = VEC_LO;
        end
      endcase
    end
  end

  // All state and registered outputs; reset may land on any clock and
  // restarts the vector fetch from a clean phase.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= VEC_LO;
      phase_q <= '0;
      lat_q   <= 8'h00;
      ir_q    <= 8'h00;
      op_q    <= 8'h00;
      pc_q    <= 16'h0000;
      a_q     <= 8'h00;
      x_q     <= 8'h00;
      y_q     <= 8'h00;
      p_q     <= STATUS_RESET;
      addr_q  <= RESET_VECTOR;
      dout_q  <= 8'h00;
      rw_q    <= 1'b1;
      sync_q  <= 1'b0;
      ce_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      lat_q   <= lat_d;
      ir_q    <= ir_d;
      op_q    <= op_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      x_q     <= x_d;
      y_q     <= y_d;
      p_q     <= p_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rw_q    <= rw_d;
      sync_q  <= sync_d;
      ce_q    <= ce_d;
      ill_q   <= ill_d;
    end
  end

  assign address_out = addr_q;
  assign data_out    = dout_q;
  assign rw          = rw_q;
  assign sync        = sync_q;
  assign cpu_ce      = ce_q;
  assign illegal_op  = ill_q;
  assign pc_dbg      = pc_q;
  assign a_dbg       = a_q;
  assign x_dbg       = x_q;
  assign y_dbg       = y_q;
  assign p_dbg       = p_q;

endmodule

// File: tb/tb_nes_cpu_sequencer.sv
// tb_nes_cpu_sequencer
//   Drives nes_cpu_sequencer from a flat 64 KiB memory image and compares
//   each instruction against an instruction-level model of the 6502 subset:
//   cycle count, next fetch address, registers, bus writes, branch dummy
//   reads and illegal-opcode pulses.

module tb_nes_cpu_sequencer;

  localparam int CLK_DIV = 12;
`ifdef CPU_PAGE_PENALTY_EN
  localparam bit PENALTY = 1'b1;
`else
  localparam bit PENALTY = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  data_in;
  logic [15:0] address_out;
  logic [7:0]  data_out;
  logic        rw;
  logic        sync;
  logic        cpu_ce;
  logic        illegal_op;
  logic [15:0] pc_dbg;
  logic [7:0]  a_dbg;
  logic [7:0]  x_dbg;
  logic [7:0]  y_dbg;
  logic [7:0]  p_dbg;

  logic [7:0]  mem [0:65535];

  assign data_in = mem[address_out];

  always #5 clock = ~clock;

  nes_cpu_sequencer #(.CLK_DIV(CLK_DIV)) dut (
    .clock       (clock),
    .reset       (reset),
    .data_in     (data_in),
    .address_out (address_out),
    .data_out    (data_out),
    .rw          (rw),
    .sync        (sync),
    .cpu_ce      (cpu_ce),
    .illegal_op  (illegal_op),
    .pc_dbg      (pc_dbg),
    .a_dbg       (a_dbg),
    .x_dbg       (x_dbg),
    .y_dbg       (y_dbg),
    .p_dbg       (p_dbg)
  );

  int errors = 0;
  int checks = 0;

  // Architectural model state
  logic [15:0] m_pc;
  logic [7:0]  m_a, m_x, m_y, m_p;

  // Expectations for the instruction being stepped
  int          e_cycles;
  logic [15:0] e_next_pc;
  bit          e_write;
  logic [15:0] e_waddr;
  logic [7:0]  e_wdata;
  bit          e_illegal;
  bit          e_fix;
  logic [15:0] e_fix_addr;

  // Observations gathered while stepping
  int          r_cycles;
  int          r_ill;
  bit          r_done;
  logic [15:0] r_addr [0:7];
  logic        r_rw   [0:7];
  logic [7:0]  r_dout [0:7];

  logic [15:0] wp;

  logic [7:0] ops [0:17] = '{8'hA9, 8'hA2, 8'hA0, 8'h29, 8'h09, 8'h49,
                             8'hE8, 8'hC8, 8'h18, 8'h38, 8'hEA, 8'h85,
                             8'h10, 8'h30, 8'h90, 8'hB0, 8'hD0, 8'hF0};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic clearMem();
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
  endtask

  task automatic emit(input logic [7:0] b);
    mem[wp] = b;
    wp = wp + 16'd1;
  endtask

  function automatic bit isSupported(input logic [7:0] opc);
    bit hit = 1'b0;
    for (int i = 0; i < 18; i++) if (ops[i] == opc) hit = 1'b1;
    return hit;
  endfunction

  // Instruction-level reference: reads the program image, updates the
  // architectural registers and predicts the bus-visible behaviour.
  task automatic modelStep();
    logic [7:0]  opc, imm, res;
    logic [15:0] after, target;
    int          len, off;
    bit          take, upd;
    opc = mem[m_pc];
    imm = mem[16'(m_pc + 16'd1)];
    len = 2; e_cycles = 2; e_write = 1'b0; e_illegal = 1'b0; e_fix = 1'b0;
    e_fix_addr = 16'h0; e_waddr = 16'h0; e_wdata = 8'h0;
    take = 1'b0; upd = 1'b0; res = 8'h0; target = 16'h0;
    case (opc)
      8'hA9: begin m_a = imm;       res = m_a; upd = 1'b1; end
      8'hA2: begin m_x = imm;       res = m_x; upd = 1'b1; end
      8'hA0: begin m_y = imm;       res = m_y; upd = 1'b1; end
      8'h29: begin m_a = m_a & imm; res = m_a; upd = 1'b1; end
      8'h09: begin m_a = m_a | imm; res = m_a; upd = 1'b1; end
      8'h49: begin m_a = m_a ^ imm; res = m_a; upd = 1'b1; end
      8'hE8: begin m_x = 8'(m_x + 1); res = m_x; upd = 1'b1; len = 1; end
      8'hC8: begin m_y = 8'(m_y + 1); res = m_y; upd = 1'b1; len = 1; end
      8'h18: begin m_p = m_p & 8'hFE; len = 1; end
      8'h38: begin m_p = m_p | 8'h01; len = 1; end
      8'hEA: len = 1;
      8'h85: begin e_cycles = 3; e_write = 1'b1; e_waddr = {8'h00, imm}; e_wdata = m_a; end
      8'h10: take = (m_p[7] == 1'b0);
      8'h30: take = (m_p[7] == 1'b1);
      8'h90: take = (m_p[0] == 1'b0);
      8'hB0: take = (m_p[0] == 1'b1);
      8'hD0: take = (m_p[1] == 1'b0);
      8'hF0: take = (m_p[1] == 1'b1);
      default: begin len = 1; e_illegal = 1'b1; end
    endcase
    if (upd) m_p = (m_p & 8'h7D) | ((res >= 8'd128) ? 8'h80 : 8'h00) | ((res == 8'd0) ? 8'h02 : 8'h00);
    after = 16'((int'(m_pc) + len) % 65536);
    if (take) begin
      off      = (imm >= 8'd128) ? int'(imm) - 256 : int'(imm);
      target   = 16'((int'(after) + off + 65536) % 65536);
      e_cycles = 3;
      if (PENALTY && (target[15:8] != after[15:8])) begin
        e_cycles   = 4;
        e_fix      = 1'b1;
        e_fix_addr = {after[15:8], target[7:0]};
      end
      m_pc = target;
    end else begin
      m_pc = after;
    end
    e_next_pc = m_pc;
  endtask

  // Walk the DUT from the start of one fetch cycle to the start of the next,
  // recording the bus at the start of every CPU cycle.
  task automatic runToFetch();
    logic prev_ce;
    r_cycles = 0; r_ill = 0; r_done = 1'b0;
    r_addr[0] = address_out; r_rw[0] = rw; r_dout[0] = data_out;
    for (int n = 0; n < CLK_DIV * 10; n++) begin
      prev_ce = cpu_ce;
      if (illegal_op) r_ill++;
      tick();
      if (prev_ce) begin
        r_cycles++;
        if (sync) begin
          r_done = 1'b1;
          break;
        end
        if (r_cycles < 8) begin
          r_addr[r_cycles] = address_out;
          r_rw[r_cycles]   = rw;
          r_dout[r_cycles] = data_out;
        end
      end
    end
  endtask

  task automatic stepInstr(input string tag);
    modelStep();
    runToFetch();
    checkOutput({tag, " reached fetch"}, 32'(r_done), 32'd1);
    checkOutput({tag, " cycles"}, 32'(r_cycles), 32'(e_cycles));
    checkOutput({tag, " fetch addr"}, 32'(address_out), 32'(e_next_pc));
    checkOutput({tag, " pc"}, 32'(pc_dbg), 32'(e_next_pc));
    checkOutput({tag, " A"}, 32'(a_dbg), 32'(m_a));
    checkOutput({tag, " X"}, 32'(x_dbg), 32'(m_x));
    checkOutput({tag, " Y"}, 32'(y_dbg), 32'(m_y));
    checkOutput({tag, " P"}, 32'(p_dbg), 32'(m_p));
    checkOutput({tag, " illegal pulses"}, 32'(r_ill), e_illegal ? 32'd1 : 32'd0);
    checkOutput({tag, " rw at fetch"}, 32'(rw), 32'd1);
    if (e_write) begin
      checkOutput({tag, " write rw"}, 32'(r_rw[2]), 32'd0);
      checkOutput({tag, " write addr"}, 32'(r_addr[2]), 32'(e_waddr));
      checkOutput({tag, " write data"}, 32'(r_dout[2]), 32'(e_wdata));
    end
    if (e_fix) checkOutput({tag, " fix dummy addr"}, 32'(r_addr[3]), 32'(e_fix_addr));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " addr"}, 32'(address_out), 32'hFFFC);
    checkOutput({tag, " rw"}, 32'(rw), 32'd1);
    checkOutput({tag, " data_out"}, 32'(data_out), 32'd0);
    checkOutput({tag, " sync"}, 32'(sync), 32'd0);
    checkOutput({tag, " cpu_ce"}, 32'(cpu_ce), 32'd0);
    checkOutput({tag, " illegal"}, 32'(illegal_op), 32'd0);
    checkOutput({tag, " pc"}, 32'(pc_dbg), 32'd0);
    checkOutput({tag, " regs"}, {8'h0, a_dbg, x_dbg, y_dbg}, 32'd0);
    checkOutput({tag, " P"}, 32'(p_dbg), 32'h34);
  endtask

  // Release reset and expect the first fetch 2 CPU cycles later at the vector target.
  task automatic waitVector(input logic [15:0] start);
    int n = 0;
    reset = 1'b0;
    do begin
      tick();
      n++;
    end while (!sync && n < 100);
    checkOutput("vector sync delay", 32'(n), 32'd24);
    checkOutput("vector fetch addr", 32'(address_out), 32'(start));
    m_pc = start; m_a = 8'h00; m_x = 8'h00; m_y = 8'h00; m_p = 8'h34;
  endtask

  task automatic applyStimulus(input logic [15:0] start);
    mem[16'hFFFC] = start[7:0];
    mem[16'hFFFD] = start[15:8];
    reset = 1'b1;
    repeat (3) tick();
    checkResetState("reset");
    waitVector(start);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int nrand;
    logic [7:0] opc;

    // Immediate ops, STA, illegal, increments with wrap, carry flag ops
    clearMem();
    wp = 16'h8000;
    emit(8'hA9); emit(8'hF0); emit(8'h29); emit(8'h0F); emit(8'h09); emit(8'h80);
    emit(8'hA9); emit(8'h5A); emit(8'h85); emit(8'h10); emit(8'h02);
    emit(8'hA2); emit(8'hFF); emit(8'hE8); emit(8'hA0); emit(8'h7F); emit(8'hC8);
    emit(8'h38); emit(8'hB0); emit(8'h00); emit(8'h18); emit(8'h90); emit(8'h00);
    emit(8'h49); emit(8'hFF); emit(8'h10); emit(8'h00); emit(8'hEA);
    applyStimulus(16'h8000);
    for (int i = 0; i < 18; i++) stepInstr($sformatf("basic#%0d", i));

    // Reset landing in the middle of a WRITE cycle
    clearMem();
    wp = 16'h8000;
    emit(8'hA9); emit(8'h5A); emit(8'h85); emit(8'h10);
    applyStimulus(16'h8000);
    stepInstr("pre-write lda");
    repeat (2 * CLK_DIV) tick();
    checkOutput("mid-write rw low", 32'(rw), 32'd0);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    checkResetState("mid-write reset");
    waitVector(16'h8000);

    // Taken branch crossing a page
    clearMem();
    wp = 16'h80FB;
    emit(8'hA9); emit(8'h00); emit(8'hF0); emit(8'h7F);
    applyStimulus(16'h80FB);
    stepInstr("page lda");
    stepInstr("page beq");
    checkOutput("page beq target", 32'(address_out), 32'h817E);
    stepInstr("page nop");

    // Backward branch looping on itself
    clearMem();
    mem[16'h8000] = 8'hD0; mem[16'h8001] = 8'hFE;
    applyStimulus(16'h8000);
    stepInstr("bne loop 1");
    stepInstr("bne loop 2");

    // Not-taken branch after Z set
    clearMem();
    wp = 16'h7FFE;
    emit(8'hA9); emit(8'h00); emit(8'hD0); emit(8'hFE);
    applyStimulus(16'h7FFE);
    stepInstr("nt lda");
    stepInstr("nt bne");

    // PC wrap past FFFF and -128 branch back across the wrap
    clearMem();
    mem[16'hFFFE] = 8'hA9; mem[16'hFFFF] = 8'h80;
    mem[16'h0000] = 8'h30; mem[16'h0001] = 8'h80;
    applyStimulus(16'hFFFE);
    stepInstr("wrap lda");
    stepInstr("wrap bmi");
    stepInstr("wrap nop");

    // Random straight-line program
    clearMem();
    wp = 16'h8000;
    nrand = 80;
    for (int i = 0; i < nrand; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        do opc = 8'($urandom_range(0, 255)); while (isSupported(opc));
        emit(opc);
      end else begin
        opc = ops[$urandom_range(0, 17)];
        emit(opc);
        case (opc)
          8'hE8, 8'hC8, 8'h18, 8'h38, 8'hEA: ;
          8'h10, 8'h30, 8'h90, 8'hB0, 8'hD0, 8'hF0: emit(8'h00);
          default: emit(8'($urandom_range(0, 255)));
        endcase
      end
    end
    applyStimulus(16'h8000);
    for (int i = 0; i < nrand; i++) stepInstr($sformatf("rand#%0d", i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
